iru_rot_engine: RTL and testbench

//  Drives the IRU coordinate compute unit and gathers its results into a rotated 20x20 image.
//  - Captures the RNN angle code and buffers one input image streamed from upstream.
//  - Sweeps every destination pixel (row-major), presents (row,col) to the compute unit, and

---
 rtl/iru_rot_engine.sv | 149 ++++++++++++++
 tb/tb_iru_rot_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/iru_rot_engine.sv
// IRU rotation engine: buffers one DIMxDIM image, sweeps destination pixels through the
// combinational coordinate unit and streams the rotated image out with valid/ready.
module iru_rot_engine #(
  parameter int               DIM     = 20,
  parameter int               PIX_W   = 8,
  parameter int               ANGLE_W = 36,
  parameter logic [PIX_W-1:0] FILL    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ANGLE_W-1:0] rnn_out,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic [ANGLE_W-1:0] cu_rnn_out,
  output logic [4:0]         cu_row_d,
  output logic [4:0]         cu_col_d,
  input  logic               cu_valid,
  input  logic [4:0]         cu_row_q,
  input  logic [4:0]         cu_col_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_pixel,
  output logic               out_last,
  output logic               done
);
  localparam int NPIX = DIM * DIM;
  localparam int AW   = $clog2(NPIX);

  typedef enum logic [1:0] {IDLE, LOAD, ROT} state_e;

  state_e             state_q, state_d;
  logic [ANGLE_W-1:0] rnn_q, rnn_d;
  logic [AW-1:0]      ld_idx_q, ld_idx_d;
  logic [4:0]         row_q, row_d, col_q, col_d;
  logic               exh_q, exh_d;
  logic               ov_q, ov_d;
  logic [PIX_W-1:0]   opix_q, opix_d;
  logic               olast_q, olast_d;
  logic               done_q, done_d;
  logic               ld_we;
  logic [AW-1:0]      src_addr;
  logic [PIX_W-1:0]   src_pix;
  logic               at_end;

  logic [PIX_W-1:0] pix_mem [NPIX];

  // Out-of-range coordinates are masked by cu_valid, so the read address is don't-care then.
  assign src_addr = AW'(cu_row_q) * AW'(DIM) + AW'(cu_col_q);
  assign src_pix  = cu_valid ? pix_mem[src_addr] : FILL;
  assign at_end   = (row_q == 5'(DIM - 1)) && (col_q == 5'(DIM - 1));

  always_comb begin
    state_d  = state_q;
    rnn_d    = rnn_q;
    ld_idx_d = ld_idx_q;
    row_d    = row_q;
    col_d    = col_q;
    exh_d    = exh_q;
    ov_d     = ov_q;
    opix_d   = opix_q;
    olast_d  = olast_q;
    done_d   = 1'b0;
    ld_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rnn_d    = rnn_out;
          ld_idx_d = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          ld_we    = 1'b1;
          ld_idx_d = ld_idx_q + 1'b1;
          if (ld_idx_q == AW'(NPIX - 1)) begin
            state_d = ROT;
            row_d   = '0;
            col_d   = '0;
            exh_d   = 1'b0;
          end
        end
      end
      ROT: begin
        if (ov_q && out_ready && olast_q) begin
          ov_d    = 1'b0;
          olast_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if ((!ov_q || out_ready) && !exh_q) begin
          ov_d    = 1'b1;
          opix_d  = src_pix;
          olast_d = at_end;
          if (at_end) exh_d = 1'b1;
          if (col_q == 5'(DIM - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rnn_q    <= '0;
      ld_idx_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      exh_q    <= 1'b0;
      ov_q     <= 1'b0;
      opix_q   <= '0;
      olast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnn_q    <= rnn_d;
      ld_idx_q <= ld_idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      exh_q    <= exh_d;
      ov_q     <= ov_d;
      opix_q   <= opix_d;
      olast_q  <= olast_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_we) pix_mem[ld_idx_q] <= in_pixel;
  end

  assign busy       = (state_q != IDLE);
  assign in_ready   = (state_q == LOAD);
  assign cu_rnn_out = rnn_q;
  assign cu_row_d   = row_q;
  assign cu_col_d   = col_q;
  assign out_valid  = ov_q;
  assign out_pixel  = opix_q;
  assign out_last   = olast_q;
  assign done       = done_q;
endmodule

// File: tb/tb_iru_rot_engine.sv
// Directed bench for iru_rot_engine with a behavioural coordinate unit (identity / 180 deg).
module tb_iru_rot_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [35:0] rnn_out = '0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic [35:0] cu_rnn_out;
  logic [4:0]  cu_row_d, cu_col_d;
  logic        cu_valid;
  logic [4:0]  cu_row_q, cu_col_q;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pixel;
  logic        out_last;
  logic        done;

  logic        mode = 1'b0;  // 0: identity, 1: 180 deg
  logic [7:0]  img  [400];
  logic [7:0]  expv [400];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  iru_rot_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rnn_out(rnn_out), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .cu_rnn_out(cu_rnn_out), .cu_row_d(cu_row_d), .cu_col_d(cu_col_d),
    .cu_valid(cu_valid), .cu_row_q(cu_row_q), .cu_col_q(cu_col_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .done(done)
  );

  // Out-of-range sources return junk coordinates so an unmasked read would show up.
  always_comb begin
    cu_valid = 1'b1;
    cu_row_q = cu_row_d;
    cu_col_q = cu_col_d;
    if (mode) begin
      if (cu_row_d >= 5'd1 && cu_col_d >= 5'd1) begin
        cu_row_q = 5'd20 - cu_row_d;
        cu_col_q = 5'd20 - cu_col_d;
      end else begin
        cu_valid = 1'b0;
        cu_row_q = 5'd31;
        cu_col_q = 5'd31;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_job(input string tag, input logic [35:0] code);
    @(negedge clk);
    start = 1'b1;
    rnn_out = code;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_rnn_cap"}, cu_rnn_out, code);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic load_img(input string tag, input bit stall, input bit pulse);
    int idx = 0;
    int cyc = 0;
    while (idx < 400 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      in_valid = stall ? cyc[0] : 1'b1;
      in_pixel = in_valid ? img[idx] : 8'hEE;
      start    = pulse && (idx == 100);
      rnn_out  = start ? 36'hF_FFFF_FFFF : rnn_out;
      if (in_valid && in_ready) idx++;
    end
    start = 1'b0;
    chk({tag, "_load_cnt"}, idx, 400);
  endtask

  task automatic collect(input string tag, input int pct, input bit pulse, input int limit,
                         input logic [35:0] code);
    int beats = 0, cyc = 0, first_v = 0, last_cyc = 0;
    int perr = 0, lerr = 0, serr = 0, dn = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_pix = '0;
    logic prev_last = 1'b0;
    while (beats < limit && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      start    = pulse && (cyc == 60);
      rnn_out  = start ? 36'hA_AAAA_AAAA : rnn_out;
      if (done) dn++;
      if (prev_stall && (!out_valid || out_pixel !== prev_pix || out_last !== prev_last)) serr++;
      if (out_valid && first_v == 0) first_v = cyc;
      out_ready = ($urandom_range(0, 99) < pct);
      if (out_valid && out_ready) begin
        if (out_pixel !== expv[beats]) perr++;
        if (out_last !== (beats == 399)) lerr++;
        beats++;
        last_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pixel;
      prev_last  = out_last;
    end
    start = 1'b0;
    chk({tag, "_beats"}, beats, limit);
    chk({tag, "_pix_err"}, perr, 0);
    chk({tag, "_last_err"}, lerr, 0);
    chk({tag, "_stall_err"}, serr, 0);
    chk({tag, "_early_done"}, dn, 0);
    chk({tag, "_first_valid_cyc"}, first_v, 2);
    chk({tag, "_rnn_hold"}, cu_rnn_out, code);
    if (pct == 100) chk({tag, "_last_cyc"}, last_cyc, limit + 1);
    if (limit == 400) begin
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_ov_clr"}, out_valid, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 1'b0);
    end
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rnn", cu_rnn_out, 36'h0);
    chk("rst_rowcol", {cu_row_d, cu_col_d}, 10'h0);
    rst_n = 1'b1;

    // Identity
    for (int i = 0; i < 400; i++) begin img[i] = 8'(i % 256); expv[i] = img[i]; end
    mode = 1'b0;
    start_job("id", 36'h0_0000_0001);
    load_img("id", 1'b0, 1'b0);
    collect("id", 100, 1'b0, 400, 36'h0_0000_0001);

    // 180 deg with input stalls
    for (int i = 0; i < 400; i++) img[i] = 8'((i * 7 + 3) % 256);
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++)
        expv[r*20+c] = (r >= 1 && c >= 1) ? img[(20-r)*20 + (20-c)] : 8'h00;
    mode = 1'b1;
    start_job("r180", 36'h1_2345_6789);
    load_img("r180", 1'b1, 1'b0);
    collect("r180", 100, 1'b0, 400, 36'h1_2345_6789);

    // Backpressure with stray start pulses
    for (int i = 0; i < 400; i++) begin img[i] = 8'((i * 13 + 5) % 256); expv[i] = img[i]; end
    mode = 1'b0;
    start_job("bp", 36'h0_0BAD_F00D);
    load_img("bp", 1'b0, 1'b1);
    collect("bp", 30, 1'b1, 400, 36'h0_0BAD_F00D);

    // Abort mid-ROT after pixel 150
    start_job("abt", 36'h0_0000_0777);
    load_img("abt", 1'b0, 1'b0);
    collect("abt", 100, 1'b0, 150, 36'h0_0000_0777);
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("abt_busy", busy, 1'b0);
    chk("abt_ov", out_valid, 1'b0);
    chk("abt_done", done, 1'b0);
    chk("abt_rnn", cu_rnn_out, 36'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (5) begin @(negedge clk); if (done) dn++; end
    chk("abt_no_done", dn, 0);

    // Fresh 180 job after abort
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++)
        expv[r*20+c] = (r >= 1 && c >= 1) ? img[(20-r)*20 + (20-c)] : 8'h00;
    mode = 1'b1;
    start_job("fresh", 36'h0_0000_0999);
    load_img("fresh", 1'b0, 1'b0);
    collect("fresh", 100, 1'b0, 400, 36'h0_0000_0999);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
